// File: rtl/led_pkg.sv
// Shared types for the LED status controller.
//   led_mode_e       : per-channel display mode (OFF / ON / BLINK / COUNT)
//   LED_DEFAULT_MODE : mode loaded into every channel by the INIT sweep
//   ctrl_state_e     : controller state (INIT sweep, then RUN)
//   pwm_cnt_w()      : PWM counter width; doubled when LED_GAMMA_EN is defined
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_COUNT = 2'd3
  } led_mode_e;

  localparam led_mode_e LED_DEFAULT_MODE = LED_COUNT;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  function automatic int pwm_cnt_w(input int pwm_bits);
`ifdef LED_GAMMA_EN
    return 2 * pwm_bits;
`else
    return pwm_bits;
`endif
  endfunction

endpackage

// File: rtl/led_pwm.sv
// Per-channel LED output stage: decodes the mode, applies PWM dimming and
// registers the LED drive bit.
// Optional feature macro: LED_GAMMA_EN (quadratic brightness curve).
// Ports:
//   clk_pix, rst_n_pix : clock, async active-low reset
//   mode, level        : channel configuration
//   pwm_cnt            : shared free-running PWM counter (PCW bits)
//   blink_bit          : shared blink phase bit
//   count_bit          : this channel's legacy counter bit
//   led                : registered LED drive
module led_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS = 4,
  parameter int PCW      = PWM_BITS
) (
  input  logic                clk_pix,
  input  logic                rst_n_pix,
  input  led_mode_e           mode,
  input  logic [PWM_BITS-1:0] level,
  input  logic [PCW-1:0]      pwm_cnt,
  input  logic                blink_bit,
  input  logic                count_bit,
  output logic                led
);

  logic [PCW-1:0] thr;
  logic           pwm_on;
  logic           led_d;

`ifdef LED_GAMMA_EN
  // PCW is 2*PWM_BITS here, so level*level cannot overflow.
  assign thr = PCW'(level) * PCW'(level);
`else
  assign thr = PCW'(level);
`endif

  // Endpoints bypass the comparator: level 0 is dark, all-ones is solid on.
  always_comb begin
    pwm_on = 1'b0;
    if (level == '0)    pwm_on = 1'b0;
    else if (&level)    pwm_on = 1'b1;
    else                pwm_on = (pwm_cnt < thr);
  end

  always_comb begin
    led_d = 1'b0;
    case (mode)
      LED_OFF:   led_d = 1'b0;
      LED_ON:    led_d = pwm_on;
      LED_BLINK: led_d = pwm_on & blink_bit;
      LED_COUNT: led_d = count_bit;
      default:   led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) led <= 1'b0;
    else            led <= led_d;
  end

endmodule

// File: rtl/led_status.sv
// LED status controller: per-channel OFF / PWM-dimmed ON / BLINK / legacy
// counter display, configured through a valid/ready write port.
// Optional feature macro: LED_GAMMA_EN (quadratic brightness curve).
// Ports:
//   clk_pix, rst_n_pix        : pixel clock, async active-low reset
//   cfg_valid / cfg_ready     : config write handshake
//   cfg_ch, cfg_mode, cfg_level : write target and payload
//   cfg_err                   : sticky, a write targeted a missing channel
//   led                       : registered LED drives
module led_status
  import led_pkg::*;
#(
  parameter int CHANNELS      = 8,
  parameter int PWM_BITS      = 4,
  parameter int PRESCALE_BITS = 23,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_pix,
  input  logic                rst_n_pix,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  led_mode_e           cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_level,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] led
);

  localparam int              PCW     = pwm_cnt_w(PWM_BITS);
  localparam logic [CH_W:0]   CH_LIM  = (CH_W+1)'(CHANNELS);
  localparam logic [CH_W-1:0] IDX_END = CH_W'(CHANNELS - 1);

  // Legacy counter split into prescaler and displayed part; together they
  // form one PRESCALE_BITS+CHANNELS bit counter that wraps to zero.
  logic [PRESCALE_BITS-1:0] cnt_lo;
  logic [CHANNELS-1:0]      cnt_hi;
  logic [PCW-1:0]           pwm_cnt;

  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      cnt_lo  <= '0;
      cnt_hi  <= '0;
      pwm_cnt <= '0;
    end else begin
      cnt_lo  <= cnt_lo + 1'b1;
      if (&cnt_lo) cnt_hi <= cnt_hi + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Controller FSM
  ctrl_state_e     state_q, state_d;
  logic [CH_W-1:0] idx_q;
  logic            init_wr;

  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) state_q <= ST_INIT;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (idx_q == IDX_END) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == ST_RUN);
    init_wr   = (state_q == ST_INIT);
  end

  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix)   idx_q <= '0;
    else if (init_wr) idx_q <= idx_q + 1'b1;
  end

  // Config write mux: INIT sweep has priority (cfg_ready is low then anyway).
  logic                in_range;
  logic                wr_en;
  logic                bad_wr;
  logic [CH_W-1:0]     wr_ch;
  led_mode_e           wr_mode;
  logic [PWM_BITS-1:0] wr_lvl;

  assign in_range = ({1'b0, cfg_ch} < CH_LIM);

  always_comb begin
    wr_en   = 1'b0;
    bad_wr  = 1'b0;
    wr_ch   = idx_q;
    wr_mode = LED_DEFAULT_MODE;
    wr_lvl  = '1;
    if (init_wr) begin
      wr_en = 1'b1;
    end else if (cfg_valid && cfg_ready) begin
      if (in_range) begin
        wr_en   = 1'b1;
        wr_ch   = cfg_ch;
        wr_mode = cfg_mode;
        wr_lvl  = cfg_level;
      end else begin
        bad_wr  = 1'b1;
      end
    end
  end

  led_mode_e                          mode_q [CHANNELS];
  logic [CHANNELS-1:0][PWM_BITS-1:0]  level_q;

  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      for (int i = 0; i < CHANNELS; i++) mode_q[i] <= LED_OFF;
      level_q <= '0;
      cfg_err <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_ch == CH_W'(i))) begin
          mode_q[i]  <= wr_mode;
          level_q[i] <= wr_lvl;
        end
      end
      if (bad_wr) cfg_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    led_pwm #(
      .PWM_BITS (PWM_BITS),
      .PCW      (PCW)
    ) u_pwm (
      .clk_pix   (clk_pix),
      .rst_n_pix (rst_n_pix),
      .mode      (mode_q[g]),
      .level     (level_q[g]),
      .pwm_cnt   (pwm_cnt),
      .blink_bit (cnt_hi[0]),
      .count_bit (cnt_hi[g]),
      .led       (led[g])
    );
  end

endmodule
